thumb_mem_arbiter: RTL and testbench

- Shares one unified 32-bit memory port between the instruction-fetch and data-access ports of the pipelined Thumb core.
- Sits between the core and a single slow memory device.
- Applies a programmable number of wait cycles per access, then returns read data with a one-cycle ready pulse.
- Arbitrates between simultaneous fetch and data requests, and inserts a bus turnaround cycle between accesses.

---
 rtl/thumb_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_thumb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/thumb_mem_arbiter.sv
// Shares one slow 32-bit memory port between Thumb fetch and data ports.
// Optional round-robin arbitration when ARB_FAIR_EN is defined.
module thumb_mem_arbiter #(
  parameter int WAIT_CYCLES = 3,
  parameter int WORD_SIZE   = 32,
  parameter int HWORD_SIZE  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_instruction_n,
  input  logic [WORD_SIZE-1:0]  instruction_address,
  output logic [HWORD_SIZE-1:0] instruction,
  output logic                  instr_ready,
  input  logic                  read_data_n,
  input  logic                  write_data_n,
  input  logic [WORD_SIZE-1:0]  data_address,
  input  logic [WORD_SIZE-1:0]  data_wdata,
  output logic [WORD_SIZE-1:0]  data_rdata,
  output logic                  data_ready,
  output logic                  mem_read_n,
  output logic                  mem_write_n,
  output logic [WORD_SIZE-1:0]  mem_address,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  input  logic [WORD_SIZE-1:0]  mem_rdata,
  output logic                  proto_err
);

  typedef enum logic [2:0] {
    IDLE,
    IFETCH,
    DREAD,
    DWRITE,
    TURN
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic [3:0] count;
  logic       hw_sel;
  logic       instr_req;
  logic       data_req;
  logic       grant_data;
  logic       unused_addr_bits;

  assign instr_req = !read_instruction_n;
  assign data_req  = !read_data_n || !write_data_n;
  assign unused_addr_bits = ^{data_address[1:0],
                              instruction_address[0]};

`ifdef ARB_FAIR_EN
  logic last_data;
  // on contention the side not served last wins
  assign grant_data = data_req && (!instr_req || !last_data);
`else
  assign grant_data = data_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      hw_sel      <= 1'b0;
      mem_read_n  <= 1'b1;
      mem_write_n <= 1'b1;
      mem_address <= '0;
      mem_wdata   <= '0;
      instruction <= '0;
      data_rdata  <= '0;
      instr_ready <= 1'b0;
      data_ready  <= 1'b0;
      proto_err   <= 1'b0;
`ifdef ARB_FAIR_EN
      last_data   <= 1'b0;
`endif
    end else begin
      instr_ready <= 1'b0;
      data_ready  <= 1'b0;
      if (!read_data_n && !write_data_n)
        proto_err <= 1'b1;
      unique case (state)
        IDLE: begin
          if (grant_data) begin
            mem_address <= {data_address[WORD_SIZE-1:2], 2'b00};
            count       <= WAIT_INIT;
`ifdef ARB_FAIR_EN
            last_data   <= 1'b1;
`endif
            if (!write_data_n) begin
              mem_wdata   <= data_wdata;
              mem_write_n <= 1'b0;
              state       <= DWRITE;
            end else begin
              mem_read_n  <= 1'b0;
              state       <= DREAD;
            end
          end else if (instr_req) begin
            mem_address <= {instruction_address[WORD_SIZE-1:2],
                            2'b00};
            hw_sel      <= instruction_address[1];
            count       <= WAIT_INIT;
            mem_read_n  <= 1'b0;
            state       <= IFETCH;
`ifdef ARB_FAIR_EN
            last_data   <= 1'b0;
`endif
          end
        end
        IFETCH, DREAD, DWRITE: begin
          if (count == 4'd0) begin
            mem_read_n  <= 1'b1;
            mem_write_n <= 1'b1;
            state       <= TURN;
            if (state == IFETCH) begin
              instr_ready <= 1'b1;
              instruction <= hw_sel
                ? mem_rdata[WORD_SIZE-1 -: HWORD_SIZE]
                : mem_rdata[HWORD_SIZE-1:0];
            end else begin
              data_ready <= 1'b1;
              if (state == DREAD)
                data_rdata <= mem_rdata;
            end
          end else begin
            count <= count - 4'd1;
          end
        end
        TURN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_thumb_mem_arbiter.sv
// Scoreboard bench for thumb_mem_arbiter: randomized request groups,
// expected completions queued in service order, checked by a monitor.
module tb_thumb_mem_arbiter;

  localparam int W = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        read_instruction_n = 1'b1;
  logic [31:0] instruction_address = '0;
  logic [15:0] instruction;
  logic        instr_ready;
  logic        read_data_n = 1'b1;
  logic        write_data_n = 1'b1;
  logic [31:0] data_address = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic        mem_read_n;
  logic        mem_write_n;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        proto_err;

  thumb_mem_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk),
    .reset(reset),
    .read_instruction_n(read_instruction_n),
    .instruction_address(instruction_address),
    .instruction(instruction),
    .instr_ready(instr_ready),
    .read_data_n(read_data_n),
    .write_data_n(write_data_n),
    .data_address(data_address),
    .data_wdata(data_wdata),
    .data_rdata(data_rdata),
    .data_ready(data_ready),
    .mem_read_n(mem_read_n),
    .mem_write_n(mem_write_n),
    .mem_address(mem_address),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h4) return 32'hDA04_2909;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign mem_rdata = memf(mem_address);

  // kind: 0 fetch, 1 data read, 2 data write
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic        perr;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   low_cnt = 0;
  logic last_wr = 1'b0;
  logic perr_seen = 1'b0;
  int   last_side = 0;

`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // monitor: invariants every cycle, scoreboard pop on each ready
  always @(negedge clk) begin
    exp_t e;
    int   akind;
    if (reset) begin
      low_cnt = 0;
    end else begin
      chk("one_strobe", 32'(!mem_read_n && !mem_write_n), 0);
      chk("one_ready", 32'(instr_ready && data_ready), 0);
      if (!mem_write_n) last_wr = 1'b1;
      else if (!mem_read_n) last_wr = 1'b0;
      if (!mem_read_n || !mem_write_n) low_cnt++;
      if (instr_ready || data_ready) begin
        akind = instr_ready ? 0 : (last_wr ? 2 : 1);
        if (q.size() == 0) begin
          chk("unexpected_ready", 32'(akind), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("kind", 32'(akind), 32'(e.kind));
          chk("mem_address", mem_address, {e.addr[31:2], 2'b00});
          chk("strobe_cycles", 32'(low_cnt), 32'(W));
          chk("strobes_high", {30'b0, mem_read_n, mem_write_n}, 3);
          case (e.kind)
            0: chk("instruction", {16'b0, instruction}, e.data);
            1: chk("data_rdata", data_rdata, e.data);
            default: chk("mem_wdata", mem_wdata, e.data);
          endcase
          if (e.kind != 0)
            chk("proto_err", 32'(proto_err), 32'(e.perr));
        end
        low_cnt = 0;
      end
    end
  end

  function automatic exp_t mk_fetch(input logic [31:0] fa);
    exp_t e;
    logic [31:0] m;
    m = memf({fa[31:2], 2'b00});
    e.kind = 0;
    e.addr = fa;
    e.data = {16'b0, fa[1] ? m[31:16] : m[15:0]};
    e.perr = 1'b0;
    return e;
  endfunction

  // d_kind: 0 none, 1 read, 2 write, 3 read+write (protocol error)
  task automatic do_group(input bit f_en, input int d_kind,
                          input logic [31:0] fa,
                          input logic [31:0] da,
                          input logic [31:0] wd);
    exp_t fe, de;
    bit   data_first;
    int   n;
    if (d_kind == 3) perr_seen = 1'b1;
    fe = mk_fetch(fa);
    de.kind = (d_kind == 1) ? 1 : 2;
    de.addr = da;
    de.data = (d_kind == 1) ? memf({da[31:2], 2'b00}) : wd;
    de.perr = perr_seen;
    data_first = !(FAIR && last_side == 1);
    if (f_en && d_kind != 0) begin
      if (data_first) begin q.push_back(de); q.push_back(fe); end
      else begin q.push_back(fe); q.push_back(de); end
      last_side = data_first ? 0 : 1;
    end else if (f_en) begin
      q.push_back(fe);
      last_side = 0;
    end else if (d_kind != 0) begin
      q.push_back(de);
      last_side = 1;
    end
    instruction_address = fa;
    data_address = da;
    data_wdata = wd;
    read_instruction_n = !f_en;
    read_data_n = !(d_kind == 1 || d_kind == 3);
    write_data_n = !(d_kind == 2 || d_kind == 3);
    n = 0;
    while ((!read_instruction_n || !read_data_n || !write_data_n)
           && n < 100) begin
      @(negedge clk);
      n++;
      if (instr_ready) read_instruction_n = 1'b1;
      if (data_ready) begin
        read_data_n = 1'b1;
        write_data_n = 1'b1;
      end
    end
    if (n >= 100) begin
      chk("group_timeout", 32'(n), 0);
      read_instruction_n = 1'b1;
      read_data_n = 1'b1;
      write_data_n = 1'b1;
    end
  endtask

  initial begin
    int r;
    int dk;
    bit fe;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_read_n", 32'(mem_read_n), 1);
    chk("rst_mem_write_n", 32'(mem_write_n), 1);
    chk("rst_instr_ready", 32'(instr_ready), 0);
    chk("rst_data_ready", 32'(data_ready), 0);
    chk("rst_proto_err", 32'(proto_err), 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_instruction", {16'b0, instruction}, 0);

    // abort a data read in its second wait cycle
    data_address = 32'h0000_0200;
    read_data_n = 1'b0;
    @(negedge clk);
    chk("abort_strobe_low", 32'(mem_read_n), 0);
    @(negedge clk);
    reset = 1'b1;
    read_data_n = 1'b1;
    @(negedge clk);
    chk("abort_mem_read_n", 32'(mem_read_n), 1);
    chk("abort_data_ready", 32'(data_ready), 0);
    chk("abort_data_rdata", data_rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (W + 2) @(negedge clk);
    chk("abort_idle_read_n", 32'(mem_read_n), 1);
    chk("abort_no_ready", 32'(data_ready), 0);

    do_group(1'b1, 0, 32'h6, 32'h0, 32'h0);
    do_group(1'b0, 2, 32'h0, 32'h104, 32'h24);
    do_group(1'b1, 1, 32'h1002, 32'h2008, 32'h0);
    do_group(1'b1, 1, 32'h3000, 32'h4004, 32'h0);
    do_group(1'b0, 3, 32'h0, 32'h50C, 32'hCAFE_F00D);
    do_group(1'b0, 1, 32'h0, 32'h600, 32'h0);
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      fe = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      dk = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
      if (!fe && dk == 0) fe = 1'b1;
      do_group(fe, dk, $urandom, $urandom, $urandom);
    end
    repeat (10) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    chk("proto_sticky", 32'(proto_err), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
